// File: rtl/vlane_dispatch.sv
// vlane_dispatch: command FIFO feeding one in-flight vector instruction broadcast to LANES lanes.
// Optional feature macro: VLANE_DISPATCH_BYPASS_EN (idle/empty dispatcher skips the FIFO).
package vect_pkg;
  typedef struct packed {
    logic [5:0] funct6;
    logic       vm;
    logic [4:0] vs2;
    logic [4:0] vs1;
    logic [2:0] funct3;
    logic [4:0] vd;
    logic [6:0] opcode;
  } arithm_instr_t;
endpackage

module vlane_dispatch
  import vect_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  arithm_instr_t                    cmd_instr_i,
  input  logic [DATA_WIDTH-1:0]            cmd_rs1_i,
  output logic                             lane_instr_req_o,
  output logic                             lane_instr_valid_o,
  output arithm_instr_t                    lane_instr_o,
  output logic [DATA_WIDTH-1:0]            lane_rs1_o,
  input  logic [LANES-1:0]                 lane_ready_i,
  output logic                             done_o,
  output logic                             busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o,
  output logic                             err_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                  state_r, next_state_s;
  arithm_instr_t           instr_mem_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   rs1_mem_r   [FIFO_DEPTH];
  logic [PW-1:0]           wptr_r, rptr_r;
  logic [CW-1:0]           count_r;
  arithm_instr_t           instr_r;
  logic [DATA_WIDTH-1:0]   rs1_r;
  logic [LANES-1:0]        pending_r, pend_next_s, pend_clear_s;
  logic                    err_r, err_set_s;
  logic                    full_s, empty_s, handshake_s, bypass_s, push_s, pop_s, done_s;

  assign full_s  = (count_r == CW'(FIFO_DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});

  assign cmd_ready_o        = !full_s && !rst_i;
  assign lane_instr_req_o   = (state_r == ST_ISSUE);
  assign lane_instr_valid_o = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
  assign lane_instr_o       = instr_r;
  assign lane_rs1_o         = rs1_r;
  assign done_o             = done_s;
  assign busy_o             = (state_r != ST_IDLE) || !empty_s;
  assign fifo_count_o       = count_r;
  assign err_o              = err_r;

  // Classify the accepted command: straight into the issue registers or into the FIFO.
  always_comb begin
    handshake_s = cmd_valid_i && cmd_ready_o;
`ifdef VLANE_DISPATCH_BYPASS_EN
    bypass_s = handshake_s && (state_r == ST_IDLE) && empty_s;
`else
    bypass_s = 1'b0;
`endif
    push_s = handshake_s && !bypass_s;
  end

  // Next-state, pop and retire decode; done is combinational on the final lane pulse.
  always_comb begin
    next_state_s = state_r;
    pend_next_s  = pending_r;
    pend_clear_s = pending_r & ~lane_ready_i;
    pop_s        = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s        = 1'b1;
          next_state_s = ST_ISSUE;
        end else if (bypass_s) begin
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        pend_next_s  = {LANES{1'b1}};
        next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        pend_next_s = pend_clear_s;
        if (pend_clear_s == {LANES{1'b0}}) begin
          done_s = 1'b1;
          if (!empty_s) begin
            pop_s        = 1'b1;
            next_state_s = ST_ISSUE;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // A completion pulse is illegal outside WAIT or for a lane that already finished.
  always_comb begin
    if (state_r == ST_WAIT) begin
      err_set_s = |(lane_ready_i & ~pending_r);
    end else begin
      err_set_s = |lane_ready_i;
    end
  end

  // FIFO storage; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      instr_mem_r[wptr_r] <= cmd_instr_i;
      rs1_mem_r[wptr_r]   <= cmd_rs1_i;
    end
  end

  // Control state, pointers, count, issue registers and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      wptr_r    <= {PW{1'b0}};
      rptr_r    <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
      pending_r <= {LANES{1'b0}};
      instr_r   <= '0;
      rs1_r     <= {DATA_WIDTH{1'b0}};
      err_r     <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      pending_r <= pend_next_s;
      err_r     <= err_r | err_set_s;
      if (push_s) wptr_r <= wptr_r + PW'(1);
      if (pop_s)  rptr_r <= rptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (pop_s) begin
        instr_r <= instr_mem_r[rptr_r];
        rs1_r   <= rs1_mem_r[rptr_r];
      end else if (bypass_s) begin
        instr_r <= cmd_instr_i;
        rs1_r   <= cmd_rs1_i;
      end
    end
  end

endmodule

// File: tb/tb_vlane_dispatch.sv
// Self-checking bench for vlane_dispatch: directed stimulus, issue payloads checked by a queue-fed monitor.
module tb_vlane_dispatch;
  import vect_pkg::*;

`ifdef VLANE_DISPATCH_BYPASS_EN
  localparam int EXP_N   = 0;
  localparam int EXP_CNT = 0;
`else
  localparam int EXP_N   = 1;
  localparam int EXP_CNT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  arithm_instr_t cmd_instr;
  logic [31:0]   cmd_rs1;
  logic          req, ivalid, done, busy, err;
  arithm_instr_t lane_instr;
  logic [31:0]   lane_rs1;
  logic [3:0]    lane_ready;
  logic [2:0]    count;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];

  vlane_dispatch #(.DATA_WIDTH(32), .LANES(4), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_instr_i(cmd_instr), .cmd_rs1_i(cmd_rs1),
    .lane_instr_req_o(req), .lane_instr_valid_o(ivalid),
    .lane_instr_o(lane_instr), .lane_rs1_o(lane_rs1),
    .lane_ready_i(lane_ready), .done_o(done), .busy_o(busy),
    .fifo_count_o(count), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out at %0t", nm, $time);
  endtask

  // Monitor: every broadcast must match the oldest outstanding command.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (done) done_cnt++;
      if (req) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req actual=%0h expected=none", {lane_instr, lane_rs1});
        end else begin
          e = exp_q.pop_front();
          check("issue_payload", {lane_instr, lane_rs1}, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [31:0] ins, input logic [31:0] r);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_instr = ins;
    cmd_rs1   = r;
    exp_q.push_back({ins, r});
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    if (!ok) fail_timeout("push");
  endtask

  task automatic wait_req(output int n);
    bit ok = 1'b0;
    n = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      if (req) ok = 1'b1;
      else begin
        step();
        n++;
      end
    end
    if (!ok) fail_timeout("wait_req");
    step();
  endtask

  task automatic drain(input int cnt, input bit gap_check);
    int n;
    for (int i = 0; i < cnt; i++) begin
      wait_req(n);
      if (gap_check) check("b2b_gap", 64'(n), 64'd0);
      lane_ready = 4'b1111;
      @(negedge clk);
      check("drain_done", 64'(done), 64'd1);
      step();
      lane_ready = 4'b0000;
    end
  endtask

  initial begin
    int n;
    int snap;
    rst = 1'b1; cmd_valid = 1'b0; cmd_instr = '0; cmd_rs1 = 32'd0; lane_ready = 4'b0000;
    repeat (3) step();
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_outputs", 64'({req, ivalid, done, busy, err}), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(cmd_ready), 64'd1);
    step();

    // Single command with staggered lane completions.
    push_cmd(32'h0000_5057, 32'h0000_1234);
    check("count_cycle1", 64'(count), 64'(EXP_CNT));
    wait_req(n);
    check("issue_latency", 64'(n), 64'(EXP_N));
    lane_ready = 4'b0001;
    @(negedge clk);
    check("wait_req_low", 64'(req), 64'd0);
    check("wait_valid", 64'(ivalid), 64'd1);
    check("wait_rs1", 64'(lane_rs1), 64'h1234);
    check("done_0001", 64'(done), 64'd0);
    step(); lane_ready = 4'b0110;
    @(negedge clk);
    check("done_0110", 64'(done), 64'd0);
    step(); lane_ready = 4'b1000;
    @(negedge clk);
    check("done_1000", 64'(done), 64'd1);
    check("busy_at_done", 64'(busy), 64'd1);
    step(); lane_ready = 4'b0000;
    @(negedge clk);
    check("done_after", 64'(done), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("err_clean", 64'(err), 64'd0);
    step();

    // Fill the FIFO while lanes stall, hold a sixth command, then drain in order across the wrap.
    for (int i = 0; i < 5; i++) push_cmd(32'h0200_0057 + 32'(i), 32'hA000_0000 + 32'(i));
    @(negedge clk);
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(cmd_ready), 64'd0);
    step();
    cmd_valid = 1'b1; cmd_instr = 32'h0200_0157; cmd_rs1 = 32'hA000_0005;
    exp_q.push_back({32'h0200_0157, 32'hA000_0005});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("held_ready", 64'(cmd_ready), 64'd0);
      step();
    end
    lane_ready = 4'b1111;
    @(negedge clk);
    check("fill_done0", 64'(done), 64'd1);
    check("ready_same_pop", 64'(cmd_ready), 64'd0);
    step(); lane_ready = 4'b0000;
    @(negedge clk);
    check("count_after_pop", 64'(count), 64'd3);
    check("ready_after_pop", 64'(cmd_ready), 64'd1);
    check("reissue", 64'(req), 64'd1);
    step(); cmd_valid = 1'b0;
    lane_ready = 4'b1111;
    @(negedge clk);
    check("refill_count", 64'(count), 64'd4);
    check("fill_done1", 64'(done), 64'd1);
    step(); lane_ready = 4'b0000;
    drain(4, 1'b1);
    @(negedge clk);
    check("fill_idle", 64'({busy, count}), 64'd0);
    step();

    // Back-to-back: three queued commands, every lane finishing at once.
    push_cmd(32'h0000_1057, 32'h0000_0B01);
    push_cmd(32'h0000_2057, 32'h0000_0B02);
    push_cmd(32'h0000_3057, 32'h0000_0B03);
    lane_ready = 4'b1111;
    @(negedge clk);
    check("b2b_done_a", 64'(done), 64'd1);
    step(); lane_ready = 4'b0000;
    drain(2, 1'b1);

    // Protocol error while idle is sticky; a later command still retires.
    lane_ready = 4'b0010;
    @(negedge clk);
    check("idle_pulse_no_done", 64'(done), 64'd0);
    step(); lane_ready = 4'b0000;
    @(negedge clk);
    check("err_set", 64'(err), 64'd1);
    repeat (3) step();
    @(negedge clk);
    check("err_sticky", 64'(err), 64'd1);
    step();
    snap = done_cnt;
    push_cmd(32'h0000_6057, 32'h0000_0E00);
    drain(1, 1'b0);
    @(negedge clk);
    check("err_retire_cnt", 64'(done_cnt - snap), 64'd1);
    check("err_still", 64'(err), 64'd1);
    step();

    // Reset in WAIT with lanes 2,3 pending and two commands queued.
    push_cmd(32'h0000_7057, 32'h0000_0D00);
    push_cmd(32'h0000_8057, 32'h0000_0D01);
    push_cmd(32'h0000_9057, 32'h0000_0D02);
    @(negedge clk);
    check("pre_rst_count", 64'(count), 64'd2);
    step();
    lane_ready = 4'b0011;
    @(negedge clk);
    check("partial_no_done", 64'(done), 64'd0);
    step(); lane_ready = 4'b0000;
    rst = 1'b1;
    exp_q.delete();
    snap = done_cnt;
    @(negedge clk);
    check("rst_ready_low", 64'(cmd_ready), 64'd0);
    step();
    @(negedge clk);
    check("midrst_outputs", 64'({req, ivalid, done, busy, err}), 64'd0);
    check("midrst_payload", 64'({lane_instr, lane_rs1}), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    step();
    rst = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check("no_done_after_rst", 64'(done_cnt - snap), 64'd0);
    check("idle_after_rst", 64'(busy), 64'd0);
    step();

    // Fresh command after reset; a repeated pulse for a finished lane flags an error.
    push_cmd(32'h0000_A057, 32'h0000_0F00);
    wait_req(n);
    check("post_rst_latency", 64'(n), 64'(EXP_N));
    lane_ready = 4'b0001;
    @(negedge clk);
    check("post_done_a", 64'(done), 64'd0);
    step();
    @(negedge clk);
    check("post_err_clear", 64'(err), 64'd0);
    lane_ready = 4'b0001;
    #1;
    step();
    lane_ready = 4'b1110;
    @(negedge clk);
    check("post_done_b", 64'(done), 64'd1);
    check("dup_pulse_err", 64'(err), 64'd1);
    step(); lane_ready = 4'b0000;
    @(negedge clk);
    check("post_idle", 64'(busy), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
